// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB command master.
package apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/apb_cmd_master.sv
// Single-outstanding command-to-APB bridge with wait-state timeout and
// a held response register.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic        cmd_write_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        busy_o
);

  localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  apb_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             accept;
  logic             aligned;
  logic             in_access;
  logic             timeout_hit;

  assign accept       = cmd_valid_i && (state_q == ST_IDLE);
  assign aligned      = (cmd_addr_i[1:0] == 2'b00);
  assign in_access    = (state_q == ST_ACCESS);
  assign wait_cnt_inc = wait_cnt_q + CNT_W'(1);
  // The abort fires on the low-PREADY cycle that brings the count to the limit.
  assign timeout_hit  = in_access && !PREADY && (wait_cnt_inc == CNT_MAX);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = aligned ? ST_SETUP : ST_RESP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (PREADY || timeout_hit) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = 1'b0;
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      ST_SETUP:  PSEL = 1'b1;
      ST_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      ST_RESP:   rsp_valid_o = 1'b1;
      default:   busy_o = 1'b1;
    endcase
  end

  // Request fields only change on acceptance, so they stay put for the whole transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      PADDR  <= '0;
      PWDATA <= '0;
      PWRITE <= 1'b0;
    end else if (accept) begin
      PADDR  <= cmd_addr_i;
      PWDATA <= cmd_wdata_i;
      PWRITE <= cmd_write_i;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt_q <= '0;
    end else if (accept && aligned) begin
      wait_cnt_q <= '0;
    end else if (in_access && !PREADY) begin
      wait_cnt_q <= wait_cnt_inc;
    end
  end

  // PREADY is tested before the timeout so a late completion still wins.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else if (accept && !aligned) begin
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b1;
      rsp_timeout_o <= 1'b0;
    end else if (in_access && PREADY) begin
      rsp_rdata_o   <= PWRITE ? 32'd0 : PRDATA;
      rsp_err_o     <= PSLVERR;
      rsp_timeout_o <= 1'b0;
    end else if (timeout_hit) begin
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b1;
      rsp_timeout_o <= 1'b1;
    end
  end

endmodule
